ppl_ctrl: RTL and testbench



---
 rtl/ppl_ctrl_pkg.sv | 31 +++
 rtl/ppl_ctrl_hazard_detect.sv | 28 ++
 rtl/ppl_ctrl.sv | 148 ++++++++++++++
 tb/tb_ppl_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ppl_ctrl_pkg.sv
// Shared widths, hold/clear bus encodings and FSM state type for the pipeline controller.
package ppl_ctrl_pkg;

   localparam int CPU_WIDTH = 16;
   localparam int DATABUS   = 16;

   localparam int HOLD_W  = 3;
   localparam int CLEAR_W = 2;

   // Each hold level freezes every stage up to and including the named one.
   localparam logic [HOLD_W-1:0] HOLD_NONE = 3'd0;
   localparam logic [HOLD_W-1:0] HOLD_PC   = 3'd1;
   localparam logic [HOLD_W-1:0] HOLD_IF   = 3'd2;
   localparam logic [HOLD_W-1:0] HOLD_EX   = 3'd3;
   localparam logic [HOLD_W-1:0] HOLD_PPL  = 3'd4;

   // Each clear level flushes every pipeline register up to the named one.
   localparam logic [CLEAR_W-1:0] CLEAR_NONE = 2'd0;
   localparam logic [CLEAR_W-1:0] CLEAR_IF   = 2'd1;
   localparam logic [CLEAR_W-1:0] CLEAR_EX   = 2'd2;
   localparam logic [CLEAR_W-1:0] CLEAR_PPL  = 2'd3;

   localparam logic [CPU_WIDTH-1:0] INT_VECTOR_DEF = 16'h0004;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_INT_SVC  = 2'd2
   } state_t;

endpackage

// File: rtl/ppl_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID read of a register that the load in EX has not yet written.
module hazard_detect
   import ppl_ctrl_pkg::*;
(
   input  logic       ex_mem_ctrl,
   input  logic       ex_rw_sel,
   input  logic       ex_reg_we,
   input  logic [2:0] ex_rd,
   input  logic [2:0] id_rs_addr,
   input  logic [2:0] id_rd_addr,
   input  logic       id_rs_use,
   input  logic       id_rd_use,
   output logic       load_use
);

   logic ex_is_load;
   logic rs_hit;
   logic rd_hit;

   // r0 is hardwired, so a load targeting it never creates a dependency.
   always_comb begin
      ex_is_load = ex_mem_ctrl & ex_rw_sel & ex_reg_we & (ex_rd != 3'd0);
      rs_hit     = id_rs_use & (id_rs_addr == ex_rd);
      rd_hit     = id_rd_use & (id_rd_addr == ex_rd);
      load_use   = ex_is_load & (rs_hit | rd_hit);
   end

endmodule

// File: rtl/ppl_ctrl.sv
// Pipeline control unit: hazard holds/flushes, PC redirect and interrupt accept/return.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_RUN      | normal execution, interrupts may be accepted
//   ST_MEM_WAIT | memory access stalled; ret_svc says where to go back to
//   ST_INT_SVC  | interrupt handler active, no nesting, waits for mret
module ppl_ctrl
   import ppl_ctrl_pkg::*;
#(
   parameter int                    CPU_WIDTH   = ppl_ctrl_pkg::CPU_WIDTH,
   parameter logic [CPU_WIDTH-1:0]  INT_VECTOR  = INT_VECTOR_DEF,
   parameter int                    MEM_TIMEOUT = 15
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ID_valid,
   input  logic [CPU_WIDTH-1:0] ID_inst_addr,
   input  logic [2:0]           ID_rs_addr,
   input  logic [2:0]           ID_rd_addr,
   input  logic                 ID_rs_use,
   input  logic                 ID_rd_use,
   input  logic [2:0]           EX_rd,
   input  logic                 EX_mem_ctrl,
   input  logic                 EX_RWSel,
   input  logic                 EX_RegWe,
   input  logic                 EX_jump,
   input  logic [CPU_WIDTH-1:0] EX_jump_addr,
   input  logic                 EX_mret,
   input  logic                 mem_req,
   input  logic                 mem_ready,
   input  logic                 int_req,
   input  logic                 int_en,
   output logic [HOLD_W-1:0]    hold_flag,
   output logic [CLEAR_W-1:0]   clear_flag,
   output logic                 pc_load,
   output logic [CPU_WIDTH-1:0] pc_target,
   output logic [CPU_WIDTH-1:0] epc,
   output logic                 int_ack,
   output logic                 int_busy,
   output logic                 bus_err
);

   localparam int              CNT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

   state_t           state;
   logic             ret_svc;
   logic [CNT_W-1:0] cnt;

   logic load_use;
   logic in_svc;
   logic stall;
   logic timeout;
   logic do_jump;
   logic do_mret;
   logic do_accept;

   hazard_detect u_hazard_detect (
      .ex_mem_ctrl (EX_mem_ctrl),
      .ex_rw_sel   (EX_RWSel),
      .ex_reg_we   (EX_RegWe),
      .ex_rd       (EX_rd),
      .id_rs_addr  (ID_rs_addr),
      .id_rd_addr  (ID_rd_addr),
      .id_rs_use   (ID_rs_use),
      .id_rd_use   (ID_rd_use),
      .load_use    (load_use)
   );

   // Event decode in priority order; MEM_WAIT behaves like the state it was entered from
   // once the access completes, so a jump or mret waiting in EX is not lost.
   always_comb begin
      in_svc    = (state == ST_INT_SVC) | ((state == ST_MEM_WAIT) & ret_svc);
      stall     = mem_req & ~mem_ready;
      timeout   = (state == ST_MEM_WAIT) & stall & (cnt == CNT_MAX);
      do_jump   = ~stall & EX_jump;
      do_mret   = ~stall & ~EX_jump & EX_mret & in_svc;
      do_accept = ~stall & ~EX_jump & ~in_svc & int_req & int_en & ID_valid;
   end

   // Flag and redirect outputs, combinational so pipeline registers react in the same cycle.
   always_comb begin
      hold_flag  = HOLD_NONE;
      clear_flag = CLEAR_NONE;
      pc_load    = 1'b0;
      pc_target  = '0;
      int_ack    = 1'b0;
      int_busy   = 1'b0;
      bus_err    = 1'b0;
      if (rst) begin
         clear_flag = CLEAR_PPL;
      end else begin
         int_busy = in_svc;
         if (timeout) begin
            bus_err = 1'b1;
         end else if (stall) begin
            hold_flag = HOLD_PPL;
         end else if (do_jump) begin
            clear_flag = CLEAR_EX;
            pc_load    = 1'b1;
            pc_target  = EX_jump_addr;
         end else if (do_mret) begin
            clear_flag = CLEAR_EX;
            pc_load    = 1'b1;
            pc_target  = epc;
         end else if (do_accept) begin
            clear_flag = CLEAR_EX;
            pc_load    = 1'b1;
            pc_target  = INT_VECTOR;
            int_ack    = 1'b1;
         end else if (load_use) begin
            hold_flag  = HOLD_IF;
            clear_flag = CLEAR_EX;
         end
      end
   end

   // State, return-state bit, stall counter and saved return address.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_RUN;
         ret_svc <= 1'b0;
         cnt     <= '0;
         epc     <= '0;
      end else if (timeout) begin
         state <= ret_svc ? ST_INT_SVC : ST_RUN;
         cnt   <= '0;
      end else if (stall) begin
         if (state != ST_MEM_WAIT) begin
            ret_svc <= (state == ST_INT_SVC);
         end
         state <= ST_MEM_WAIT;
         cnt   <= cnt + CNT_W'(1);
      end else begin
         cnt <= '0;
         if (do_mret) begin
            state <= ST_RUN;
         end else if (do_accept) begin
            state <= ST_INT_SVC;
            epc   <= ID_inst_addr;
         end else begin
            state <= in_svc ? ST_INT_SVC : ST_RUN;
         end
      end
   end

endmodule

// File: tb/tb_ppl_ctrl.sv
// Self-checking bench for ppl_ctrl: vector table plus hand-built multi-cycle sequences.
module tb_ppl_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ID_valid;
   logic [15:0] ID_inst_addr;
   logic [2:0]  ID_rs_addr, ID_rd_addr;
   logic        ID_rs_use, ID_rd_use;
   logic [2:0]  EX_rd;
   logic        EX_mem_ctrl, EX_RWSel, EX_RegWe, EX_jump, EX_mret;
   logic [15:0] EX_jump_addr;
   logic        mem_req, mem_ready, int_req, int_en;
   logic [2:0]  hold_flag;
   logic [1:0]  clear_flag;
   logic        pc_load;
   logic [15:0] pc_target, epc;
   logic        int_ack, int_busy, bus_err;

   ppl_ctrl dut (
      .clk(clk), .rst(rst), .ID_valid(ID_valid), .ID_inst_addr(ID_inst_addr),
      .ID_rs_addr(ID_rs_addr), .ID_rd_addr(ID_rd_addr), .ID_rs_use(ID_rs_use),
      .ID_rd_use(ID_rd_use), .EX_rd(EX_rd), .EX_mem_ctrl(EX_mem_ctrl),
      .EX_RWSel(EX_RWSel), .EX_RegWe(EX_RegWe), .EX_jump(EX_jump),
      .EX_jump_addr(EX_jump_addr), .EX_mret(EX_mret), .mem_req(mem_req),
      .mem_ready(mem_ready), .int_req(int_req), .int_en(int_en),
      .hold_flag(hold_flag), .clear_flag(clear_flag), .pc_load(pc_load),
      .pc_target(pc_target), .epc(epc), .int_ack(int_ack), .int_busy(int_busy),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rst, idv;
      logic [15:0] ida;
      logic [2:0]  rs, rd;
      logic        rsu, rdu;
      logic [2:0]  exrd;
      logic        memc, rws, rwe, jmp;
      logic [15:0] ja;
      logic        mret, mreq, mrdy, ireq, ien;
      logic [2:0]  e_hold;
      logic [1:0]  e_clr;
      logic        e_pcl;
      logic [15:0] e_tgt;
      logic        e_ack, e_busy, e_berr;
      logic [15:0] e_epc;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   vec_t v;
   int   vectors = 0;
   int   miscompares = 0;

   function automatic vec_t nv(input string n, input logic [15:0] epc_e, input logic busy_e);
      vec_t r;
      r.name = n;   r.rst = 0;  r.idv = 0;  r.ida = 0;   r.rs = 0;   r.rd = 0;
      r.rsu = 0;    r.rdu = 0;  r.exrd = 0; r.memc = 0;  r.rws = 0;  r.rwe = 0;
      r.jmp = 0;    r.ja = 0;   r.mret = 0; r.mreq = 0;  r.mrdy = 0; r.ireq = 0;
      r.ien = 0;    r.e_hold = 0; r.e_clr = 0; r.e_pcl = 0; r.e_tgt = 0;
      r.e_ack = 0;  r.e_busy = busy_e; r.e_berr = 0; r.e_epc = epc_e;
      return r;
   endfunction

   task automatic chk(input string vn, input string f, input logic [15:0] act, input logic [15:0] ex);
      if (act !== ex) begin
         miscompares++;
         $display("FAIL %s.%s: got %h expected %h", vn, f, act, ex);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, then compare before the next edge.
   task automatic apply(input vec_t a);
      vec_t e;
      @(negedge clk);
      rst = a.rst; ID_valid = a.idv; ID_inst_addr = a.ida; ID_rs_addr = a.rs; ID_rd_addr = a.rd;
      ID_rs_use = a.rsu; ID_rd_use = a.rdu; EX_rd = a.exrd; EX_mem_ctrl = a.memc;
      EX_RWSel = a.rws; EX_RegWe = a.rwe; EX_jump = a.jmp; EX_jump_addr = a.ja;
      EX_mret = a.mret; mem_req = a.mreq; mem_ready = a.mrdy; int_req = a.ireq; int_en = a.ien;
      sb.push_back(a);
      #2;
      e = sb.pop_front();
      vectors++;
      chk(e.name, "hold_flag",  {13'd0, hold_flag},  {13'd0, e.e_hold});
      chk(e.name, "clear_flag", {14'd0, clear_flag}, {14'd0, e.e_clr});
      chk(e.name, "pc_load",    {15'd0, pc_load},    {15'd0, e.e_pcl});
      chk(e.name, "pc_target",  pc_target,           e.e_tgt);
      chk(e.name, "int_ack",    {15'd0, int_ack},    {15'd0, e.e_ack});
      chk(e.name, "int_busy",   {15'd0, int_busy},   {15'd0, e.e_busy});
      chk(e.name, "bus_err",    {15'd0, bus_err},    {15'd0, e.e_berr});
      chk(e.name, "epc",        epc,                 e.e_epc);
   endtask

   function automatic vec_t lu(input string n, input logic [15:0] ep, input logic bz);
      vec_t r = nv(n, ep, bz);
      r.memc = 1; r.rws = 1; r.rwe = 1; r.exrd = 3; r.rs = 3; r.rsu = 1;
      r.e_hold = 3'd2; r.e_clr = 2'd2;
      return r;
   endfunction

   function automatic vec_t irq(input string n, input logic [15:0] addr, input logic [15:0] ep);
      vec_t r = nv(n, ep, 0);
      r.ireq = 1; r.ien = 1; r.idv = 1; r.ida = addr;
      r.e_clr = 2'd2; r.e_pcl = 1; r.e_tgt = 16'h0004; r.e_ack = 1;
      return r;
   endfunction

   function automatic vec_t stl(input string n, input logic [15:0] ep, input logic bz);
      vec_t r = nv(n, ep, bz);
      r.mreq = 1; r.mrdy = 0; r.e_hold = 3'd4;
      return r;
   endfunction

   initial begin
      // ---------------- vector table ----------------
      v = nv("rst_state", 16'h0000, 0); v.rst = 1; v.e_clr = 2'd3; tbl.push_back(v);
      tbl.push_back(nv("idle0", 16'h0000, 0));
      tbl.push_back(lu("lu_rs", 16'h0000, 0));
      tbl.push_back(nv("lu_after", 16'h0000, 0));
      v = nv("lu_rd", 16'h0000, 0); v.memc = 1; v.rws = 1; v.rwe = 1; v.exrd = 5; v.rd = 5; v.rdu = 1;
      v.e_hold = 3'd2; v.e_clr = 2'd2; tbl.push_back(v);
      v = lu("lu_r0", 16'h0000, 0); v.exrd = 0; v.rs = 0; v.e_hold = 0; v.e_clr = 0; tbl.push_back(v);
      v = lu("lu_nouse", 16'h0000, 0); v.rsu = 0; v.e_hold = 0; v.e_clr = 0; tbl.push_back(v);
      v = lu("lu_store", 16'h0000, 0); v.rws = 0; v.e_hold = 0; v.e_clr = 0; tbl.push_back(v);
      v = nv("jump", 16'h0000, 0); v.jmp = 1; v.ja = 16'h0040;
      v.e_clr = 2'd2; v.e_pcl = 1; v.e_tgt = 16'h0040; tbl.push_back(v);
      tbl.push_back(nv("jump_after", 16'h0000, 0));
      v = nv("mret_in_run", 16'h0000, 0); v.mret = 1; tbl.push_back(v);
      v = nv("irq_disabled", 16'h0000, 0); v.ireq = 1; v.idv = 1; v.ida = 16'h0010; tbl.push_back(v);
      v = irq("jump_vs_irq", 16'h0010, 16'h0000); v.jmp = 1; v.ja = 16'h0080;
      v.e_tgt = 16'h0080; v.e_ack = 0; tbl.push_back(v);
      tbl.push_back(irq("irq_accept", 16'h0022, 16'h0000));
      v = nv("svc_no_nest", 16'h0022, 1); v.ireq = 1; v.ien = 1; v.idv = 1; v.ida = 16'h0024; tbl.push_back(v);
      tbl.push_back(lu("svc_lu", 16'h0022, 1));
      v = nv("svc_jump", 16'h0022, 1); v.jmp = 1; v.ja = 16'h0100;
      v.e_clr = 2'd2; v.e_pcl = 1; v.e_tgt = 16'h0100; tbl.push_back(v);
      v = nv("mret", 16'h0022, 1); v.mret = 1; v.e_clr = 2'd2; v.e_pcl = 1; v.e_tgt = 16'h0022; tbl.push_back(v);
      tbl.push_back(nv("after_mret", 16'h0022, 0));
      v = stl("stall_jump", 16'h0022, 0); v.jmp = 1; v.ja = 16'h0200; tbl.push_back(v);
      v = stl("stall_irq", 16'h0022, 0); v.ireq = 1; v.ien = 1; v.idv = 1; v.ida = 16'h0030; tbl.push_back(v);
      v = nv("stall_ready", 16'h0022, 0); v.mreq = 1; v.mrdy = 1; tbl.push_back(v);
      tbl.push_back(nv("idle1", 16'h0022, 0));

      rst = 1; ID_valid = 0; ID_inst_addr = 0; ID_rs_addr = 0; ID_rd_addr = 0; ID_rs_use = 0;
      ID_rd_use = 0; EX_rd = 0; EX_mem_ctrl = 0; EX_RWSel = 0; EX_RegWe = 0; EX_jump = 0;
      EX_jump_addr = 0; EX_mret = 0; mem_req = 0; mem_ready = 0; int_req = 0; int_en = 0;
      repeat (2) @(posedge clk);

      foreach (tbl[i]) apply(tbl[i]);

      // ---------------- memory wait, 3 stalled cycles then ready ----------------
      for (int i = 0; i < 3; i++) apply(stl("mw_stall", 16'h0022, 0));
      v = nv("mw_ready", 16'h0022, 0); v.mreq = 1; v.mrdy = 1; apply(v);
      apply(nv("mw_idle", 16'h0022, 0));

      // ---------------- memory timeout ----------------
      for (int i = 0; i < 15; i++) apply(stl("to_stall", 16'h0022, 0));
      v = stl("to_berr", 16'h0022, 0); v.e_hold = 0; v.e_berr = 1; apply(v);
      apply(nv("to_after", 16'h0022, 0));

      // ---------------- stall inside the handler returns to it ----------------
      apply(irq("sv_accept", 16'h0050, 16'h0022));
      apply(stl("sv_stall", 16'h0050, 1));
      v = stl("sv_stall_irq", 16'h0050, 1); v.ireq = 1; v.ien = 1; v.idv = 1; apply(v);
      v = nv("sv_ready_irq", 16'h0050, 1); v.mreq = 1; v.mrdy = 1; v.ireq = 1; v.ien = 1; v.idv = 1;
      apply(v);
      v = nv("sv_mret", 16'h0050, 1); v.mret = 1; v.e_clr = 2'd2; v.e_pcl = 1; v.e_tgt = 16'h0050; apply(v);
      apply(nv("sv_done", 16'h0050, 0));

      // ---------------- reset while in the handler ----------------
      apply(irq("ri_accept", 16'h0060, 16'h0050));
      apply(nv("ri_busy", 16'h0060, 1));
      v = nv("ri_rst", 16'h0060, 0); v.rst = 1; v.ireq = 1; v.ien = 1; v.idv = 1; v.mret = 1;
      v.e_clr = 2'd3; apply(v);
      apply(nv("ri_post", 16'h0000, 0));
      apply(irq("ri_run_again", 16'h0070, 16'h0000));
      apply(nv("ri_busy2", 16'h0070, 1));
      v = nv("ri_mret", 16'h0070, 1); v.mret = 1; v.e_clr = 2'd2; v.e_pcl = 1; v.e_tgt = 16'h0070; apply(v);

      // ---------------- reset while stalled clears the timeout counter ----------------
      for (int i = 0; i < 3; i++) apply(stl("rm_stall", 16'h0070, 0));
      v = stl("rm_rst", 16'h0070, 0); v.rst = 1; v.e_hold = 0; v.e_clr = 2'd3; apply(v);
      for (int i = 0; i < 15; i++) apply(stl("rm_stall2", 16'h0000, 0));
      v = stl("rm_berr", 16'h0000, 0); v.e_hold = 0; v.e_berr = 1; apply(v);
      apply(nv("rm_idle", 16'h0000, 0));

      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
